// File: rtl/sb_cfg_pkg.sv
// Shared constants and FSM state type for the switch-box configuration loader.
// Each routing word is eight 2-bit select fields; select code 3 has no source.
package sb_cfg_pkg;

    localparam int         SB_FIELD_W     = 2;
    localparam int         SB_NUM_FIELDS  = 8;
    localparam logic [1:0] SB_SEL_INVALID = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } sb_state_t;

endpackage

// File: rtl/sb_cfg_word_check.sv
// Flags a routing word that contains any illegal select field.
module sb_cfg_word_check
    import sb_cfg_pkg::*;
(
    input  logic [SB_FIELD_W*SB_NUM_FIELDS-1:0] i_word,
    output logic                                o_bad
);

    always_comb begin
        o_bad = 1'b0;
        for (int f = 0; f < SB_NUM_FIELDS; f++) begin
            if (i_word[f*SB_FIELD_W +: SB_FIELD_W] == SB_SEL_INVALID) begin
                o_bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_box_cfg_loader.sv
// Collects a framed stream of routing words into a shadow buffer and commits
// the whole set to the switch-box column in one edge, or rejects it.
module switch_box_cfg_loader
    import sb_cfg_pkg::*;
#(
    parameter int NUM_BOXES = 4,
    parameter int CFG_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [CFG_W-1:0]           wr_data,
    output logic [NUM_BOXES*CFG_W-1:0] cfg_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W = $clog2(NUM_BOXES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOXES - 1);

    sb_state_t                  r_state;
    logic [IDX_W-1:0]           r_idx;
    logic                       r_bad;
    logic                       r_done;
    logic                       r_err;
    logic [NUM_BOXES*CFG_W-1:0] r_shadow;
    logic [NUM_BOXES*CFG_W-1:0] r_cfg;
    logic                       w_word_bad;

    sb_cfg_word_check u_check (
        .i_word (wr_data),
        .o_bad  (w_word_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_bad    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_shadow <= '0;
            r_cfg    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                        r_bad   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                LOAD: begin
                    // A restart wins over a word presented on the same cycle.
                    if (start) begin
                        r_idx <= '0;
                        r_bad <= 1'b0;
                        r_err <= 1'b0;
                    end else if (wr_valid) begin
                        r_shadow[int'(r_idx)*CFG_W +: CFG_W] <= wr_data;
                        r_idx <= r_idx + 1'b1;
                        r_bad <= r_bad | w_word_bad;
                        if (r_idx == LAST_IDX) begin
                            r_state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    if (r_bad) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cfg  <= r_shadow;
                        r_done <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_ready = (r_state == LOAD);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign err      = r_err;
    assign cfg_out  = r_cfg;

endmodule

// File: tb/tb_switch_box_cfg_loader.sv
// Directed bench for the switch-box configuration loader (NUM_BOXES = 4).
module tb_switch_box_cfg_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [63:0] cfg_out;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] chk_word;
    logic        chk_bad;

    int errors = 0;
    int checks = 0;

    switch_box_cfg_loader #(.NUM_BOXES(4), .CFG_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .cfg_out  (cfg_out),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    sb_cfg_word_check u_sb_chk (
        .i_word (chk_word),
        .o_bad  (chk_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends four words; returns one sample after the final handshake edge.
    task automatic send_words(input logic [63:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) begin
                wr_valid = 1'b0;
                wr_data  = 16'hFFFF;
                tick();
            end
            wr_valid = 1'b1;
            wr_data  = w[i*16 +: 16];
            tick();
        end
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (cfg_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_cfg: got %h want 0", cfg_out);
        end
        checks++;
        if ({wr_ready, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {wr_ready, busy, done, err});
        end
    endtask

    task automatic test_good;
        logic [63:0] w;
        logic        exp_bad;
        w = 64'h9A26_0000_2492_1249;
        exp_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_word = w[i*16 +: 16];
            #1;
            exp_bad = exp_bad | chk_bad;
        end
        pulse_start();
        checks++;
        if ({wr_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL good_load: got %b want 11", {wr_ready, busy});
        end
        send_words(w, 0);
        checks++;
        if ({wr_ready, busy, done, cfg_out} !== {3'b010, 64'h0}) begin
            errors++;
            $display("FAIL good_commit_cycle: got %b %h want 010 0",
                     {wr_ready, busy, done}, cfg_out);
        end
        tick();
        checks++;
        if (cfg_out !== 64'h9A26_0000_2492_1249) begin
            errors++;
            $display("FAIL good_cfg: got %h want 9a26000024921249", cfg_out);
        end
        checks++;
        if ({done, busy, err} !== {1'b1, 1'b0, exp_bad}) begin
            errors++;
            $display("FAIL good_flags: got %b want 100", {done, busy, err});
        end
        checks++;
        if (cfg_out[47:32] !== 16'h0000 || cfg_out[15:0] !== 16'h1249) begin
            errors++;
            $display("FAIL good_box_slices: got %h %h want 0000 1249",
                     cfg_out[47:32], cfg_out[15:0]);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL good_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_bad_frame;
        chk_word = 16'h0003;
        #1;
        checks++;
        if (chk_bad !== 1'b1) begin
            errors++;
            $display("FAIL bad_word_check: got %b want 1", chk_bad);
        end
        pulse_start();
        send_words(64'h0000_0003_AAAA_5555, 0);
        tick();
        checks++;
        if ({err, done, busy} !== 3'b100) begin
            errors++;
            $display("FAIL bad_flags: got %b want 100", {err, done, busy});
        end
        checks++;
        if (cfg_out !== 64'h9A26_0000_2492_1249) begin
            errors++;
            $display("FAIL bad_cfg_kept: got %h want 9a26000024921249",
                     cfg_out);
        end
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL bad_err_sticky: got %b want 1", err);
        end
        pulse_start();
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL bad_err_clear: got %b want 01", {err, busy});
        end
    endtask

    task automatic test_backpressure;
        int accepted_idle;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        accepted_idle = 0;
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        repeat (3) begin
            if (wr_ready !== 1'b0) accepted_idle++;
            tick();
        end
        checks++;
        if (accepted_idle != 0) begin
            errors++;
            $display("FAIL bp_idle_ready: got %0d ready cycles want 0",
                     accepted_idle);
        end
        wr_valid = 1'b0;
        pulse_start();
        send_words(64'h1818_2121_5A5A_A5A5, 5);
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_commit_ready: got %b want 0", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        checks++;
        if ({cfg_out, done, err} !== {64'h1818_2121_5A5A_A5A5, 2'b10}) begin
            errors++;
            $display("FAIL bp_cfg: got %h %b want 18182121 5a5aa5a5 10",
                     cfg_out, {done, err});
        end
        pulse_start();
        send_words(64'h1818_2121_5A5A_A5A5, 0);
        tick();
        checks++;
        if ({cfg_out, done, err} !== {64'h1818_2121_5A5A_A5A5, 2'b10}) begin
            errors++;
            $display("FAIL bp_refill: got %h %b want same 10",
                     cfg_out, {done, err});
        end
    endtask

    task automatic test_abort;
        int ndone;
        pulse_start();
        wr_valid = 1'b1;
        wr_data  = 16'h3333;
        tick();
        wr_data  = 16'h1111;
        tick();
        start    = 1'b1;
        wr_data  = 16'hFFFF;
        tick();
        start    = 1'b0;
        wr_valid = 1'b0;
        checks++;
        if ({busy, cfg_out} !== {1'b1, 64'h1818_2121_5A5A_A5A5}) begin
            errors++;
            $display("FAIL abort_hold: got %b %h want 1 old cfg",
                     busy, cfg_out);
        end
        send_words(64'h0220_0110_0202_0101, 0);
        ndone = 0;
        repeat (4) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL abort_done_count: got %0d want 1", ndone);
        end
        checks++;
        if ({cfg_out, err} !== {64'h0220_0110_0202_0101, 1'b0}) begin
            errors++;
            $display("FAIL abort_cfg: got %h %b want 0220011002020101 0",
                     cfg_out, err);
        end
    endtask

    task automatic test_reset_mid;
        pulse_start();
        wr_valid = 1'b1;
        wr_data  = 16'h0101;
        tick();
        tick();
        wr_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        checks++;
        if ({cfg_out, busy, wr_ready} !== {64'h0, 2'b00}) begin
            errors++;
            $display("FAIL mid_reset: got %h %b want 0 00",
                     cfg_out, {busy, wr_ready});
        end
    endtask

    task automatic test_back_to_back;
        pulse_start();
        send_words(64'h1000_0100_0010_0001, 0);
        start = 1'b1;
        tick();
        checks++;
        if ({done, busy, cfg_out} !== {2'b10, 64'h1000_0100_0010_0001}) begin
            errors++;
            $display("FAIL b2b_first: got %b %h want 10 1000010000100001",
                     {done, busy}, cfg_out);
        end
        tick();
        start = 1'b0;
        checks++;
        if ({busy, wr_ready} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_restart: got %b want 11", {busy, wr_ready});
        end
        send_words(64'h0002_0020_0200_2000, 0);
        tick();
        checks++;
        if ({done, err, cfg_out} !== {2'b10, 64'h0002_0020_0200_2000}) begin
            errors++;
            $display("FAIL b2b_second: got %b %h want 10 0002002002002000",
                     {done, err}, cfg_out);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 16'h0000;
        chk_word = 16'h0000;
        test_reset();
        test_good();
        test_bad_frame();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/switch_box_cfg_loader.md
# switch_box_cfg_loader

Configuration controller for a column of `switch_box_element_two` instances. It accepts a framed stream of 16-bit routing words over a valid/ready port and checks each word for illegal select codes. Words are collected in a shadow buffer, and the whole set is committed atomically to the switch boxes' `c` inputs, so the routing fabric never sees a partially loaded configuration.

## Interface
- `NUM_BOXES`, default 4: number of switch boxes driven; legal range 1..64.
- `CFG_W`, default 16: configuration bits per box; fixed at 8 fields × 2 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle pulse that opens a new frame.
- `wr_valid` input 1: `wr_data` holds a config word.
- `wr_ready` output 1: loader accepts a word this cycle.
- `wr_data` input `CFG_W`: config word for box index `idx`; box 0 comes first.
- `cfg_out` output `NUM_BOXES*CFG_W`: active config; box i occupies bits `[i*16+15 : i*16]`, feeding that box's `c`.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse when a frame commits.
- `err` output 1: the last frame was rejected; sticky until the next `start` or `reset`.

## Operation
- Each word holds eight 2-bit select fields, `c[1:0]` through `c[15:14]`.
  - Codes 0..2 are legal.
  - Code 3 is illegal, because the switch box output has no defined source.
- FSM states are IDLE, LOAD and COMMIT.
- IDLE:
  - `wr_ready`=0.
  - `start` moves to LOAD, clears `idx` to 0, clears the internal `bad` flag and clears `err`.
- LOAD:
  - `wr_ready`=1.
  - A handshake (`wr_valid & wr_ready`) writes `shadow[idx]` and increments `idx`.
  - If any field of the word equals 3, `bad` is set.
  - The handshake on `idx == NUM_BOXES-1` moves to COMMIT.
- COMMIT (exactly one cycle, `wr_ready`=0):
  - If `bad`=0: `cfg_out` ← shadow and `done`=1.
  - If `bad`=1: `cfg_out` is unchanged, `err`=1 and `done`=0.
  - The FSM returns to IDLE.
- `start` during LOAD aborts the frame:
  - `idx`=0, `bad`=0, `err`=0.
  - The FSM stays in LOAD.
  - `cfg_out` is untouched.
  - Any word presented in the same cycle as `start` is ignored.
- `start` during COMMIT is ignored.
- `wr_valid` in IDLE or COMMIT is not accepted and has no effect.
- `idx` is `$clog2(NUM_BOXES+1)` bits wide and never wraps. It is reset to 0 on every `start` and on `reset`.

## Timing
- Values after `reset`:
  - state=IDLE, `idx`=0.
  - `cfg_out` all zeros, which is the legal default routing with every field set to select 0.
  - `shadow` all zeros.
  - `wr_ready`=0, `busy`=0, `done`=0, `err`=0.
- `reset` has priority over every other input. Reset mid-frame discards the shadow and restores the zero `cfg_out`.
- `wr_ready` and `busy` are decoded from registered state only; there is no combinational path from `wr_valid`.
- Latency: with the final word accepted at edge k, the loader is in COMMIT during cycle k→k+1.
  - At edge k+1, `cfg_out` and `done` update together, or `err` if the frame was rejected.
  - `busy` falls at edge k+1.
- Minimum frame is `NUM_BOXES`+2 cycles: the `start` cycle, N word cycles, then the commit.
- `cfg_out` changes only at a COMMIT edge or at `reset`, with all boxes changing on the same edge.
- Back-to-back frames: `start` is legal in the cycle `done` is high.

## Structure
- Package `sb_cfg_pkg` contains:
  - `SB_FIELD_W`=2, `SB_NUM_FIELDS`=8, `SB_SEL_INVALID`=2'd3.
  - The state enum {IDLE, LOAD, COMMIT}.
- Sub-module `sb_cfg_word_check`: combinational, takes the 16-bit word and outputs `bad`. It is instantiated once in the loader and also reused by the bench's scoreboard.
- The shadow and active buffers are flat registers of `NUM_BOXES*16` bits, with writes indexed by `idx`.

## Test plan
- Reset, then sample: `cfg_out`=0, `wr_ready`=0, `busy`=0, `done`=0, `err`=0.
- Good frame, `NUM_BOXES`=4:
  - Stimulus: `start`, then words 16'h1249, 16'h2492, 16'h0000, 16'h9A26 with `wr_valid` held.
  - Required: `cfg_out`=64'h9A26_0000_2492_1249 and `done`=1 exactly 1 cycle after the 4th handshake.
  - Then drive `ni`/`ei`/`si`/`wi` on the four boxes and check each output's routing.
- Bad frame: the 3rd word is 16'h0003.
  - Required: after commit, `err`=1, `done`=0, and `cfg_out` still holds the previous frame.
  - `err` clears on the next `start`.
- Backpressure: `wr_valid` is toggled randomly, with gaps of 0..5 cycles.
  - Required: the same committed result as the gap-free frame.
  - No word is accepted while in IDLE or COMMIT.
- Abort:
  - Stimulus: `start`, two words, `start` again, then four new words.
  - Required: only the four new words appear in `cfg_out`, and exactly one `done` pulse occurs.
- Mid-frame reset and back-to-back:
  - `reset` after 2 words → `cfg_out`=0 and IDLE.
  - `start` in the `done` cycle → the second frame commits correctly.
